// File: rtl/id_inst_buffer_if.sv
// id_inst_buffer_if: fetch/decode handshake, branch and flush signals of the instruction buffer
interface id_inst_buffer_if #(parameter int DEPTH = 8);
    localparam int AW = $clog2(DEPTH);
    logic          if_valid_i;
    logic [31:0]   if_pc_i;
    logic [31:0]   if_inst_i;
    logic          if_ready_o;
    logic          id_valid_o;
    logic [31:0]   id_pc_o;
    logic [31:0]   id_inst_o;
    logic          id_in_delayslot_o;
    logic          id_ready_i;
    logic          branch_taken_i;
    logic [31:0]   branch_target_i;
    logic          flush_i;
    logic          redirect_o;
    logic [31:0]   redirect_addr_o;
    logic [AW:0]   count_o;
    modport slave (
        input  if_valid_i, if_pc_i, if_inst_i, id_ready_i, branch_taken_i, branch_target_i, flush_i,
        output if_ready_o, id_valid_o, id_pc_o, id_inst_o, id_in_delayslot_o, redirect_o,
               redirect_addr_o, count_o
    );
    modport master (
        output if_valid_i, if_pc_i, if_inst_i, id_ready_i, branch_taken_i, branch_target_i, flush_i,
        input  if_ready_o, id_valid_o, id_pc_o, id_inst_o, id_in_delayslot_o, redirect_o,
               redirect_addr_o, count_o
    );
endinterface

// File: rtl/id_inst_buffer.sv
// id_inst_buffer: IF->ID FIFO of {pc, inst} with delay-slot retention, fetch redirect and flush
module id_inst_buffer #(
    parameter int DEPTH = 8
) (
    input logic             clk,
    input logic             rst,
    id_inst_buffer_if.slave bus
);
    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {RUN, WAIT_DS, REDIR} state_t;

    state_t        state, nxt;
    logic [63:0]   mem [DEPTH];
    logic [AW-1:0] rd_ptr, wr_ptr;
    logic [AW:0]   count;
    logic [31:0]   target;
    logic          ds_pending, redirect;
    logic          full, empty, push, pop, take, keep, wr_en;

    always_comb begin
        full  = count == (AW+1)'(DEPTH);
        empty = count == '0;
        pop   = !empty & bus.id_ready_i;
        push  = bus.if_valid_i & !full & (state != REDIR);
        take  = pop & bus.branch_taken_i & (state == RUN);
        keep  = take & (count > (AW+1)'(1));
        wr_en = push & !keep & !bus.flush_i;
        nxt   = state == REDIR   ? RUN :
                state == WAIT_DS ? (push ? REDIR : WAIT_DS) :
                take             ? ((keep | push) ? REDIR : WAIT_DS) : RUN;
    end

    assign bus.if_ready_o                 = !full & (state != REDIR);
    assign bus.id_valid_o                 = !empty;
    assign {bus.id_pc_o, bus.id_inst_o}   = empty ? 64'h0 : mem[rd_ptr];
    assign bus.id_in_delayslot_o          = ds_pending & !empty;
    assign bus.redirect_o                 = redirect;
    assign bus.redirect_addr_o            = target;
    assign bus.count_o                    = count;

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_ptr] <= {bus.if_pc_i, bus.if_inst_i};
    end

    // A taken branch with entries behind it keeps only the delay slot at rd_ptr+1.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state      <= RUN;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            ds_pending <= 1'b0;
            redirect   <= 1'b0;
            target     <= '0;
        end else if (bus.flush_i) begin
            state      <= RUN;
            count      <= '0;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            ds_pending <= 1'b0;
            redirect   <= 1'b0;
        end else begin
            state    <= nxt;
            redirect <= nxt == REDIR;
            if (pop) begin
                rd_ptr     <= rd_ptr + AW'(1);
                ds_pending <= bus.branch_taken_i;
            end
            if (take) target <= bus.branch_target_i;
            if (keep) begin
                count  <= (AW+1)'(1);
                wr_ptr <= rd_ptr + AW'(2);
            end else begin
                if (push) wr_ptr <= wr_ptr + AW'(1);
                count <= count + (AW+1)'(push) - (AW+1)'(pop);
            end
        end
    end
endmodule

// File: tb/tb_id_inst_buffer.sv
// tb_id_inst_buffer: directed and random stimulus checked against a queue-based reference model
module tb_id_inst_buffer;
    localparam int DEPTH = 8;

    logic clk = 1'b0;
    logic rst = 1'b0;
    id_inst_buffer_if #(.DEPTH(DEPTH)) bus();
    id_inst_buffer #(.DEPTH(DEPTH)) dut (.clk(clk), .rst(rst), .bus(bus));

    always #5 clk = ~clk;

    int          n_chk = 0;
    int          n_err = 0;
    logic [63:0] q[$];
    int          ms;
    logic        mds;
    logic [31:0] mtgt;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h, expected %h", tag, got, exp);
        end
    endtask

    task automatic mreset();
        q.delete();
        ms   = 0;
        mds  = 1'b0;
        mtgt = '0;
    endtask

    task automatic idle();
        bus.if_valid_i      = 1'b0;
        bus.if_pc_i         = '0;
        bus.if_inst_i       = '0;
        bus.id_ready_i      = 1'b0;
        bus.branch_taken_i  = 1'b0;
        bus.branch_target_i = '0;
        bus.flush_i         = 1'b0;
    endtask

    task automatic check_outputs();
        logic [63:0] head;
        head = q.size() != 0 ? q[0] : 64'h0;
        chk("count", 64'(bus.count_o), 64'(q.size()));
        chk("valid", 64'(bus.id_valid_o), 64'(q.size() != 0));
        chk("head", {bus.id_pc_o, bus.id_inst_o}, head);
        chk("ready", 64'(bus.if_ready_o), 64'(q.size() < DEPTH && ms != 2));
        chk("ds", 64'(bus.id_in_delayslot_o), 64'(mds && q.size() != 0));
        chk("redirect", 64'(bus.redirect_o), 64'(ms == 2));
        if (ms == 2) chk("raddr", 64'(bus.redirect_addr_o), 64'(mtgt));
    endtask

    // Reference: ms 0 = normal, 1 = waiting for delay slot, 2 = redirect cycle
    task automatic model_step(input logic v, input logic [31:0] pc, input logic [31:0] inst,
                              input logic rdy, input logic bt, input logic [31:0] tgt, input logic fl);
        logic        push, pop, was_normal;
        logic [63:0] e;
        if (fl) begin
            q.delete();
            ms  = 0;
            mds = 1'b0;
            return;
        end
        push       = v && q.size() < DEPTH && ms != 2;
        pop        = q.size() != 0 && rdy;
        was_normal = ms == 0;
        if (pop) begin
            void'(q.pop_front());
            mds = bt;
        end
        if (pop && bt && was_normal) begin
            mtgt = tgt;
            if (q.size() >= 1) begin
                e = q[0];
                q.delete();
                q.push_back(e);
                ms = 2;
            end else if (push) begin
                q.push_back({pc, inst});
                ms = 2;
            end else ms = 1;
        end else begin
            if (push) q.push_back({pc, inst});
            ms = ms == 2 ? 0 : ms == 1 ? (push ? 2 : 1) : 0;
        end
    endtask

    task automatic cyc(input logic v, input logic [31:0] pc, input logic rdy, input logic bt,
                       input logic [31:0] tgt, input logic fl);
        logic [31:0] inst;
        inst                = $urandom;
        bus.if_valid_i      = v;
        bus.if_pc_i         = pc;
        bus.if_inst_i       = inst;
        bus.id_ready_i      = rdy;
        bus.branch_taken_i  = bt;
        bus.branch_target_i = tgt;
        bus.flush_i         = fl;
        @(negedge clk);
        check_outputs();
        @(posedge clk);
        model_step(v, pc, inst, rdy, bt, tgt, fl);
        #1;
    endtask

    initial begin
        idle();
        mreset();
        #12;
        chk("rst_count", 64'(bus.count_o), 64'h0);
        chk("rst_valid", 64'(bus.id_valid_o), 64'h0);
        chk("rst_head", {bus.id_pc_o, bus.id_inst_o}, 64'h0);
        chk("rst_ds", 64'(bus.id_in_delayslot_o), 64'h0);
        chk("rst_redirect", 64'(bus.redirect_o), 64'h0);
        chk("rst_raddr", 64'(bus.redirect_addr_o), 64'h0);
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        chk("rst_ready", 64'(bus.if_ready_o), 64'h1);

        for (int i = 0; i < 8; i++) cyc(1'b1, 32'h100 + 32'(4 * i), 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 32'h120, 1'b0, 1'b0, '0, 1'b0);
        chk("full_count", 64'(bus.count_o), 64'd8);
        chk("full_ready", 64'(bus.if_ready_o), 64'h0);
        for (int i = 0; i < 8; i++) begin
            chk("drain_pc", 64'(bus.id_pc_o), 64'(32'h100 + 32'(4 * i)));
            cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);
        end
        chk("empty_count", 64'(bus.count_o), 64'h0);
        chk("empty_valid", 64'(bus.id_valid_o), 64'h0);

        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h1000 + 32'(4 * i), 1'b0, 1'b0, '0, 1'b0);
        for (int i = 3; i < 23; i++) cyc(1'b1, 32'h1000 + 32'(4 * i), 1'b1, 1'b0, '0, 1'b0);
        chk("wrap_count", 64'(bus.count_o), 64'd3);
        for (int i = 0; i < 3; i++) cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h200 + 32'(4 * i), 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1, 32'h400, 1'b0);
        chk("br_count", 64'(bus.count_o), 64'h1);
        chk("br_pc", 64'(bus.id_pc_o), 64'h204);
        chk("br_ds", 64'(bus.id_in_delayslot_o), 64'h1);
        chk("br_redirect", 64'(bus.redirect_o), 64'h1);
        chk("br_raddr", 64'(bus.redirect_addr_o), 64'h400);
        chk("br_ready", 64'(bus.if_ready_o), 64'h0);
        cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        chk("br_redirect_end", 64'(bus.redirect_o), 64'h0);
        cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

        cyc(1'b1, 32'h300, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b1, 32'h500, 1'b0);
        chk("wds_redirect", 64'(bus.redirect_o), 64'h0);
        chk("wds_ready", 64'(bus.if_ready_o), 64'h1);
        cyc(1'b1, 32'h304, 1'b0, 1'b0, '0, 1'b0);
        chk("wds_redir_on", 64'(bus.redirect_o), 64'h1);
        chk("wds_raddr", 64'(bus.redirect_addr_o), 64'h500);
        chk("wds_pc", 64'(bus.id_pc_o), 64'h304);
        chk("wds_ds", 64'(bus.id_in_delayslot_o), 64'h1);
        cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b0, '0, 1'b1, 1'b0, '0, 1'b0);

        for (int i = 0; i < 3; i++) cyc(1'b1, 32'h700 + 32'(4 * i), 1'b0, 1'b0, '0, 1'b0);
        cyc(1'b1, 32'h70C, 1'b1, 1'b1, 32'h600, 1'b1);
        chk("fl_count", 64'(bus.count_o), 64'h0);
        chk("fl_redirect", 64'(bus.redirect_o), 64'h0);
        chk("fl_ds", 64'(bus.id_in_delayslot_o), 64'h0);

        for (int i = 0; i < 3000; i++)
            cyc($urandom_range(0, 9) < 7, $urandom, $urandom_range(0, 9) < 6,
                $urandom_range(0, 4) == 0, $urandom, $urandom_range(0, 49) == 0);

        cyc(1'b0, '0, 1'b0, 1'b0, '0, 1'b1);
        for (int i = 0; i < 5; i++) cyc(1'b1, 32'h800 + 32'(4 * i), 1'b0, 1'b0, '0, 1'b0);
        chk("ar_pre_count", 64'(bus.count_o), 64'd5);
        #2 rst = 1'b0;
        idle();
        #1;
        chk("ar_count", 64'(bus.count_o), 64'h0);
        chk("ar_valid", 64'(bus.id_valid_o), 64'h0);
        chk("ar_head", {bus.id_pc_o, bus.id_inst_o}, 64'h0);
        chk("ar_redirect", 64'(bus.redirect_o), 64'h0);
        mreset();
        @(negedge clk);
        #2 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 4; i++) cyc(1'b1, 32'h900 + 32'(4 * i), 1'b1, 1'b0, '0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end
endmodule
